// File: rtl/serial_add32.sv
// Slice-serial adder: x = d + y + cin, one SLICE-bit ripple add per clock,
// least-significant slice first, with a start/busy/done handshake.
module serial_add32 #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x,
    output logic             cout,
    output logic             overflow
);

    // state  | meaning
    // S_IDLE | waiting for start, result registers hold the last answer
    // S_RUN  | adding slice cnt_q, LSB slice first
    // S_DONE | one-cycle done pulse, a new start is accepted here too

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [SLICE-1:0] d_sl, y_sl, sum_sl;
    logic             c_msb, c_out;

    // Ripple through the slice bit by bit; the carry entering the top bit
    // is only meaningful on the last slice, where it feeds overflow.
    always_comb begin
        logic c;
        d_sl   = d_q[cnt_q*SLICE +: SLICE];
        y_sl   = y_q[cnt_q*SLICE +: SLICE];
        sum_sl = '0;
        c      = carry_q;
        c_msb  = 1'b0;
        for (int b = 0; b < SLICE; b++) begin
            sum_sl[b] = d_sl[b] ^ y_sl[b] ^ c;
            if (b == SLICE - 1) c_msb = c;
            c = (d_sl[b] & y_sl[b]) | (c & (d_sl[b] ^ y_sl[b]));
        end
        c_out = c;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        y_d     = y_q;
        carry_d = carry_q;
        x_d     = x_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    d_d     = d;
                    y_d     = y;
                    carry_d = cin;
                    cnt_d   = '0;
                    x_d     = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                x_d[cnt_q*SLICE +: SLICE] = sum_sl;
                carry_d = c_out;
                if (cnt_q == CW'(N - 1)) begin
                    cout_d  = c_out;
                    ovf_d   = c_msb ^ c_out;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            x_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            y_q     <= y_d;
            carry_q <= carry_d;
            x_q     <= x_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign x        = x_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add32.sv
// Bench for serial_add32: directed corner cases, random inverse-subtract
// checks and handshake scenarios against a plain-arithmetic adder model.
module tb_serial_add32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] d, y, x;
    logic        cin;
    logic        busy, done, cout, overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_add32 dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .d        (d),
        .y        (y),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .x        (x),
        .cout     (cout),
        .overflow (overflow)
    );

    // {overflow, cout, x} of a + b + c
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic c);
        logic [32:0] s;
        logic        v;
        s = {1'b0, a} + {1'b0, b} + {32'd0, c};
        v = (a[31] == b[31]) && (s[31] != a[31]);
        return {v, s};
    endfunction

    // Start sampled on the posedge inside; returns at the negedge after it.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c);
        @(negedge clk);
        d = a; y = b; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d = $urandom; y = $urandom; cin = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; d = '0; y = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, cout, overflow, x} !== 36'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b cout=%b ovf=%b x=%h, want all 0",
                     busy, done, cout, overflow, x);
        end
        // reset and start together: reset wins
        start = 1'b1; d = 32'h5; y = 32'h5;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_beats_start: got busy=%b want 0", busy);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat;
        logic [33:0] e;
        issue(32'h3, 32'h6, 1'b0);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        wait_done(lat);
        total++;
        if (lat != 8) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 8", lat);
        end
        total++;
        if ({overflow, cout, x} !== {2'b00, 32'h9}) begin
            bad++;
            $display("FAIL basic_result: got ovf=%b cout=%b x=%h want 0 0 00000009",
                     overflow, cout, x);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_one_cycle: got done=%b want 0", done);
        end
        // partial result: slices appear LSB first, one per cycle
        e = model(32'h12345678, 32'h11111111, 1'b0);
        issue(32'h12345678, 32'h11111111, 1'b0);
        total++;
        if (x !== 32'h0) begin
            bad++;
            $display("FAIL start_clears_x: got %h want 00000000", x);
        end
        @(negedge clk);
        total++;
        if (x !== (e[31:0] & 32'h0000000F)) begin
            bad++;
            $display("FAIL partial_slice0: got %h want %h", x, e[31:0] & 32'hF);
        end
        @(negedge clk);
        total++;
        if (x !== (e[31:0] & 32'h000000FF)) begin
            bad++;
            $display("FAIL partial_slice1: got %h want %h", x, e[31:0] & 32'hFF);
        end
        wait_done(lat);
        total++;
        if (lat != 6 || {overflow, cout, x} !== e) begin
            bad++;
            $display("FAIL partial_final: got lat=%0d x=%h want lat=6 x=%h", lat, x, e[31:0]);
        end
    endtask

    task automatic test_corners;
        logic [31:0] ta [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000,
                                32'h00000000, 32'hFFFFFFFF};
        logic [31:0] tb [6] = '{32'h00000001, 32'h00000000, 32'h00000001, 32'h80000000,
                                32'h00000000, 32'hFFFFFFFF};
        logic        tc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [33:0] want [6] = '{{2'b01, 32'h00000000}, {2'b01, 32'h00000000},
                                  {2'b10, 32'h80000000}, {2'b11, 32'h00000000},
                                  {2'b00, 32'h00000001}, {2'b01, 32'hFFFFFFFF}};
        int lat;
        for (int i = 0; i < 6; i++) begin
            issue(ta[i], tb[i], tc[i]);
            wait_done(lat);
            total++;
            if (lat != 8 || {overflow, cout, x} !== want[i]) begin
                bad++;
                $display("FAIL corner%0d: got lat=%0d ovf=%b cout=%b x=%h want lat=8 ovf=%b cout=%b x=%h",
                         i, lat, overflow, cout, x, want[i][33], want[i][32], want[i][31:0]);
            end
        end
    endtask

    task automatic test_persistence;
        int lat;
        issue(32'hFFFFFFFF, 32'h2, 1'b0);
        wait_done(lat);
        repeat (5) @(negedge clk);
        total++;
        if ({busy, done, overflow, cout, x} !== {4'b0001, 32'h1}) begin
            bad++;
            $display("FAIL persist: got busy=%b done=%b ovf=%b cout=%b x=%h want 0 0 0 1 00000001",
                     busy, done, overflow, cout, x);
        end
        issue(32'h3, 32'h6, 1'b0);
        total++;
        if ({overflow, cout, x} !== 34'd0) begin
            bad++;
            $display("FAIL start_clears: got ovf=%b cout=%b x=%h want 0 0 00000000",
                     overflow, cout, x);
        end
        wait_done(lat);
    endtask

    task automatic test_random_inverse;
        logic [31:0] x0, yy, dd;
        logic        c;
        logic [33:0] e;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            x0 = $urandom; yy = $urandom;
            dd = x0 - yy;
            e  = model(dd, yy, 1'b0);
            issue(dd, yy, 1'b0);
            wait_done(lat);
            total++;
            if (lat != 8 || x !== x0 || {overflow, cout} !== e[33:32]) begin
                bad++;
                $display("FAIL inverse%0d: got lat=%0d x=%h ovf=%b cout=%b want lat=8 x=%h ovf=%b cout=%b",
                         i, lat, x, overflow, cout, x0, e[33], e[32]);
            end
        end
        for (int i = 0; i < 200; i++) begin
            dd = $urandom; yy = $urandom; c = 1'($urandom);
            e  = model(dd, yy, c);
            issue(dd, yy, c);
            wait_done(lat);
            total++;
            if (lat != 8 || {overflow, cout, x} !== e) begin
                bad++;
                $display("FAIL random%0d: got lat=%0d x=%h ovf=%b cout=%b want x=%h ovf=%b cout=%b",
                         i, lat, x, overflow, cout, e[31:0], e[33], e[32]);
            end
        end
    endtask

    task automatic test_busy_ignore;
        logic [33:0] e;
        int lat;
        e = model(32'h01020304, 32'h10203040, 1'b1);
        issue(32'h01020304, 32'h10203040, 1'b1);
        repeat (2) @(negedge clk);
        d = 32'hDEADBEEF; y = 32'h12345678; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        total++;
        if (lat + 3 != 8 || {overflow, cout, x} !== e) begin
            bad++;
            $display("FAIL busy_ignore: got lat=%0d x=%h want lat=8 x=%h", lat + 3, x, e[31:0]);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL not_queued: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        logic [33:0] e1, e2;
        int lat;
        e1 = model(32'hAAAA5555, 32'h5555AAAA, 1'b1);
        e2 = model(32'h7FFF0000, 32'h00010000, 1'b0);
        issue(32'hAAAA5555, 32'h5555AAAA, 1'b1);
        wait_done(lat);
        total++;
        if ({overflow, cout, x} !== e1) begin
            bad++;
            $display("FAIL b2b_first: got ovf=%b cout=%b x=%h want ovf=%b cout=%b x=%h",
                     overflow, cout, x, e1[33], e1[32], e1[31:0]);
        end
        d = 32'h7FFF0000; y = 32'h00010000; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept: got busy=%b want 1", busy);
        end
        wait_done(lat);
        total++;
        if (lat + 1 != 9 || {overflow, cout, x} !== e2) begin
            bad++;
            $display("FAIL b2b_second: got gap=%0d x=%h want gap=9 x=%h", lat + 1, x, e2[31:0]);
        end
    endtask

    task automatic test_reset_midop;
        logic [33:0] e;
        int lat;
        int seen;
        issue(32'h0F0F0F0F, 32'h01010101, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || x !== 32'h0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_midop: got busy=%b done=%b x=%h want 0 0 00000000", busy, done, x);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL no_done_after_reset: got %0d pulses want 0", seen);
        end
        e = model(32'h89ABCDEF, 32'h76543210, 1'b1);
        issue(32'h89ABCDEF, 32'h76543210, 1'b1);
        wait_done(lat);
        total++;
        if (lat != 8 || {overflow, cout, x} !== e) begin
            bad++;
            $display("FAIL after_reset_op: got lat=%0d x=%h cout=%b want lat=8 x=%h cout=%b",
                     lat, x, cout, e[31:0], e[32]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_persistence();
        test_random_inverse();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
